// File: rtl/bmi_calc_unit.sv
// bmi_calc_unit: fetches a user's height/weight from the store and computes
// BMI x10 = floor(weight*SCALE / height^2) with a bit-serial restoring divider.
module bmi_calc_unit #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned SCALE  = 100000,
    parameter int unsigned NUM_W  = 29,
    parameter int unsigned OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  user_index_in,
    output logic [IDX_W-1:0]  mem_index,
    input  logic [DATA_W-1:0] height_in,
    input  logic [DATA_W-1:0] weight_in,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  bmi_x10,
    output logic              bmi_err,
    output logic              bmi_sat,
    output logic [IDX_W-1:0]  result_index
);

    localparam int unsigned DEN_W = 2 * DATA_W;
    localparam int unsigned REM_W = DEN_W + 1;
    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] height_r, weight_r;
    logic [NUM_W-1:0]  num_r;
    logic [NUM_W-2:0]  quo_r;
    logic [NUM_W-1:0]  quo_next;
    logic [DEN_W-1:0]  den_r;
    logic [DEN_W-1:0]  rem_r, rem_next;
    logic [REM_W-1:0]  rem_shift;
    logic [CNT_W-1:0]  cnt_r;
    logic              qbit;
    logic              last_iter;
    logic              quo_ovf;

    // Next-state selection and one restoring-division step
    always_comb begin
        state_next = state;
        rem_shift  = {rem_r, num_r[NUM_W-1]};
        qbit       = (rem_shift >= {1'b0, den_r});
        rem_next   = qbit ? DEN_W'(rem_shift - {1'b0, den_r}) : DEN_W'(rem_shift);
        quo_next   = {quo_r, qbit};
        last_iter  = (cnt_r == CNT_W'(1));
        quo_ovf    = |quo_next[NUM_W-1:OUT_W];
        case (state)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: state_next = S_MUL;
            S_MUL:   state_next = (height_r == '0) ? S_DONE : S_DIV;
            S_DIV:   if (last_iter) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_index    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bmi_x10      <= '0;
            bmi_err      <= 1'b0;
            bmi_sat      <= 1'b0;
            result_index <= '0;
            height_r     <= '0;
            weight_r     <= '0;
            num_r        <= '0;
            den_r        <= '0;
            rem_r        <= '0;
            quo_r        <= '0;
            cnt_r        <= '0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_index <= user_index_in;
                        bmi_x10   <= '0;
                        bmi_err   <= 1'b0;
                        bmi_sat   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    height_r <= height_in;
                    weight_r <= weight_in;
                end
                S_MUL: begin
                    num_r <= NUM_W'(weight_r) * NUM_W'(SCALE);
                    den_r <= DEN_W'(height_r) * DEN_W'(height_r);
                    rem_r <= '0;
                    quo_r <= '0;
                    cnt_r <= CNT_W'(NUM_W);
                    if (height_r == '0) begin
                        bmi_err      <= 1'b1;
                        bmi_x10      <= '0;
                        bmi_sat      <= 1'b0;
                        result_index <= mem_index;
                    end
                end
                S_DIV: begin
                    num_r <= num_r << 1;
                    rem_r <= rem_next;
                    quo_r <= quo_next[NUM_W-2:0];
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (last_iter) begin
                        result_index <= mem_index;
                        if (quo_ovf) begin
                            bmi_x10 <= '1;
                            bmi_sat <= 1'b1;
                        end else begin
                            bmi_x10 <= quo_next[OUT_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bmi_calc_unit.sv
// Testbench for bmi_calc_unit: behavioural store plus arithmetic BMI reference.
module tb_bmi_calc_unit;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned NUM_W  = 29;
    localparam int unsigned OUT_W  = 16;
    localparam int          LAT    = NUM_W + 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic [IDX_W-1:0]  user_index_in;
    logic [IDX_W-1:0]  mem_index;
    logic [DATA_W-1:0] height_in;
    logic [DATA_W-1:0] weight_in;
    logic              busy;
    logic              done;
    logic [OUT_W-1:0]  bmi_x10;
    logic              bmi_err;
    logic              bmi_sat;
    logic [IDX_W-1:0]  result_index;

    logic [DATA_W-1:0] h_mem [32];
    logic [DATA_W-1:0] w_mem [32];

    int n_cmp;
    int n_err;

    assign height_in = h_mem[mem_index];
    assign weight_in = w_mem[mem_index];

    bmi_calc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .user_index_in (user_index_in),
        .mem_index     (mem_index),
        .height_in     (height_in),
        .weight_in     (weight_in),
        .busy          (busy),
        .done          (done),
        .bmi_x10       (bmi_x10),
        .bmi_err       (bmi_err),
        .bmi_sat       (bmi_sat),
        .result_index  (result_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [IDX_W-1:0] idx);
        user_index_in = idx;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Edges counted from the start edge until done is seen (capped at 100).
    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    // Reference: BMI x10 from plain integer arithmetic.
    function automatic logic [OUT_W+1:0] ref_bmi(input int h, input int w);
        longint unsigned q;
        if (h == 0) return {16'd0, 1'b1, 1'b0};
        q = (longint'(w) * 100000) / (longint'(h) * h);
        if (q > 65535) return {16'hFFFF, 1'b0, 1'b1};
        return {16'(q), 1'b0, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({mem_index, busy, done, bmi_x10, bmi_err, bmi_sat, result_index} !== '0) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: got mi=%0d busy=%b done=%b bmi=%0d err=%b sat=%b ri=%0d, want all 0",
                         i, mem_index, busy, done, bmi_x10, bmi_err, bmi_sat, result_index);
            end
        end
    endtask

    task automatic test_basic();
        int edges;
        h_mem[3] = 12'd175; w_mem[3] = 12'd70;
        issue(5'd3);
        n_cmp++;
        if (mem_index !== 5'd3 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_fetch: got mi=%0d busy=%b, want mi=3 busy=1", mem_index, busy);
        end
        wait_done(edges);
        n_cmp++;
        if (edges != LAT) begin
            n_err++;
            $display("FAIL basic_latency: got %0d edges, want %0d", edges, LAT);
        end
        n_cmp++;
        if ({bmi_x10, bmi_err, bmi_sat, result_index, busy} !== {16'd228, 1'b0, 1'b0, 5'd3, 1'b1}) begin
            n_err++;
            $display("FAIL basic_result: got bmi=%0d err=%b sat=%b ri=%0d busy=%b, want 228 0 0 3 1",
                     bmi_x10, bmi_err, bmi_sat, result_index, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || bmi_x10 !== 16'd228) begin
            n_err++;
            $display("FAIL basic_after: got done=%b busy=%b bmi=%0d, want 0 0 228", done, busy, bmi_x10);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        h_mem[7] = 12'd160; w_mem[7] = 12'd50;
        h_mem[9] = 12'd0;   w_mem[9] = 12'd80;
        issue(5'd7);
        wait_done(edges);
        n_cmp++;
        if (edges != LAT || bmi_x10 !== 16'd195 || bmi_err !== 1'b0 || result_index !== 5'd7) begin
            n_err++;
            $display("FAIL b2b_user7: got edges=%0d bmi=%0d err=%b ri=%0d, want %0d 195 0 7",
                     edges, bmi_x10, bmi_err, result_index, LAT);
        end
        // start held through DONE: ignored there, accepted in the following IDLE cycle
        user_index_in = 5'd9;
        start = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_index !== 5'd7) begin
            n_err++;
            $display("FAIL b2b_done_ignore: got busy=%b done=%b mi=%0d, want 0 0 7", busy, done, mem_index);
        end
        tick();
        start = 1'b0;
        wait_done(edges);
        n_cmp++;
        if (edges != 2 || bmi_x10 !== 16'd0 || bmi_err !== 1'b1 || bmi_sat !== 1'b0 || result_index !== 5'd9) begin
            n_err++;
            $display("FAIL b2b_user9: got edges=%0d bmi=%0d err=%b sat=%b ri=%0d, want 2 0 1 0 9",
                     edges, bmi_x10, bmi_err, bmi_sat, result_index);
        end
        tick();
    endtask

    task automatic test_saturation();
        int edges;
        h_mem[1] = 12'd1; w_mem[1] = 12'd4095;
        issue(5'd1);
        wait_done(edges);
        n_cmp++;
        if (edges != LAT || {bmi_x10, bmi_err, bmi_sat, result_index} !== {16'hFFFF, 1'b0, 1'b1, 5'd1}) begin
            n_err++;
            $display("FAIL saturation: got edges=%0d bmi=%0d err=%b sat=%b ri=%0d, want %0d 65535 0 1 1",
                     edges, bmi_x10, bmi_err, bmi_sat, result_index, LAT);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int edges;
        int pulses;
        issue(5'd3);
        repeat (12) tick();
        user_index_in = 5'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 13;
        pulses = 0;
        while (done !== 1'b1 && edges < 100) begin
            tick();
            edges++;
        end
        n_cmp++;
        if (edges != LAT || bmi_x10 !== 16'd228 || result_index !== 5'd3 || mem_index !== 5'd3) begin
            n_err++;
            $display("FAIL ignored_start: got edges=%0d bmi=%0d ri=%0d mi=%0d, want %0d 228 3 3",
                     edges, bmi_x10, result_index, mem_index, LAT);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_single_done: got extra pulses=%0d busy=%b, want 0 0", pulses, busy);
        end
    endtask

    task automatic test_reset_midrun();
        int edges;
        int pulses;
        issue(5'd3);
        repeat (16) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({mem_index, busy, done, bmi_x10, bmi_err, bmi_sat, result_index} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: got mi=%0d busy=%b done=%b bmi=%0d err=%b sat=%b ri=%0d, want all 0",
                     mem_index, busy, done, bmi_x10, bmi_err, bmi_sat, result_index);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL midrun_no_done: got %0d busy/done cycles, want 0", pulses);
        end
        issue(5'd3);
        wait_done(edges);
        n_cmp++;
        if (edges != LAT || bmi_x10 !== 16'd228 || result_index !== 5'd3) begin
            n_err++;
            $display("FAIL midrun_restart: got edges=%0d bmi=%0d ri=%0d, want %0d 228 3",
                     edges, bmi_x10, result_index, LAT);
        end
        tick();
    endtask

    task automatic test_random();
        int edges;
        int h;
        int w;
        int exp_lat;
        logic [IDX_W-1:0] idx;
        logic [OUT_W+1:0] exp;
        for (int t = 0; t < 16; t++) begin
            idx = IDX_W'($urandom_range(0, 31));
            case ($urandom_range(0, 4))
                0:       h = 0;
                1:       h = $urandom_range(1, 20);
                default: h = $urandom_range(100, 4095);
            endcase
            w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4095);
            h_mem[idx] = DATA_W'(h);
            w_mem[idx] = DATA_W'(w);
            exp = ref_bmi(h, w);
            exp_lat = (h == 0) ? 2 : LAT;
            issue(idx);
            wait_done(edges);
            n_cmp++;
            if (edges != exp_lat || {bmi_x10, bmi_err, bmi_sat, result_index} !== {exp, idx}) begin
                n_err++;
                $display("FAIL random_%0d h=%0d w=%0d: got edges=%0d bmi=%0d err=%b sat=%b ri=%0d, want %0d %0d %b %b %0d",
                         t, h, w, edges, bmi_x10, bmi_err, bmi_sat, result_index,
                         exp_lat, exp[OUT_W+1:2], exp[1], exp[0], idx);
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        start = 1'b0;
        user_index_in = '0;
        for (int i = 0; i < 32; i++) begin
            h_mem[i] = '0;
            w_mem[i] = '0;
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_ignored_start();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
